// File: rtl/rr_ack_arbiter_n.sv
// Per-slave round-robin arbiter: locks one W_ACK master for a whole transaction and
// routes the slave's ack / read-data-valid pulses to that master.

module rr_ack_lane #(
  parameter int SW = 2
) (
  input  logic [SW-1:0] s_no,
  input  logic [SW-1:0] tgt,
  input  logic [1:0]    stat,
  output logic          elig
);
  // A master competes only while it targets this slave and is waiting for the ack.
  assign elig = (tgt == s_no) && (stat == 2'd2);
endmodule

module rr_ack_arbiter_n #(
  parameter int N_MAS  = 4,
  parameter int SW     = 2,
  parameter int TO_CYC = 64,
  parameter int IDW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SW-1:0]         s_no,
  input  logic [N_MAS*SW-1:0]   sfor,
  input  logic [N_MAS*2-1:0]    req_stat,
  input  logic                  ack_in,
  input  logic                  ack_rd,
  input  logic                  rdata_vld_in,
  output logic [N_MAS-1:0]      ack,
  output logic [N_MAS-1:0]      rdata_vld,
  output logic [N_MAS-1:0]      gnt,
  output logic [IDW-1:0]        gnt_id,
  output logic                  busy,
  output logic                  timeout_err
);
  localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = (TO_CYC > 0) ? CW'(TO_CYC - 1) : '0;

  typedef enum logic [1:0] {IDLE, GRANT, DATA} state_t;

  state_t                  state_q, state_d;
  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [N_MAS-1:0]        gnt_d, ack_d, rvld_d;
  logic [IDW-1:0]          gnt_id_d;
  logic                    busy_d, to_d;

  logic [N_MAS-1:0][SW-1:0] sfor_a;
  logic [N_MAS-1:0][1:0]    stat_a;
  logic [N_MAS-1:0]         elig;
  logic                     found;
  logic [IDW-1:0]           win;
  logic [N_MAS-1:0]         win_oh;
  logic                     timed_out;

  assign sfor_a = sfor;
  assign stat_a = req_stat;

  generate
    for (genvar i = 0; i < N_MAS; i++) begin : g_lane
      rr_ack_lane #(.SW(SW)) u_lane (
        .s_no (s_no),
        .tgt  (sfor_a[i]),
        .stat (stat_a[i]),
        .elig (elig[i])
      );
    end
  endgenerate

  // Rotating priority: the search starts just past the last owner.
  always_comb begin
    int j;
    j      = 0;
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    for (int k = 1; k <= N_MAS; k++) begin
      j = (int'(ptr_q) + k) % N_MAS;
      if (!found && elig[j]) begin
        found     = 1'b1;
        win       = IDW'(j);
        win_oh[j] = 1'b1;
      end
    end
  end

  assign timed_out = (TO_CYC != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt;
    gnt_id_d = gnt_id;
    busy_d   = busy;
    ack_d    = '0;
    rvld_d   = '0;
    to_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = GRANT;
          ptr_d    = win;
          cnt_d    = '0;
          gnt_d    = win_oh;
          gnt_id_d = win;
          busy_d   = 1'b1;
        end
      end
      GRANT: begin
        // Ack beats both withdrawal and timeout in the same cycle.
        if (ack_in) begin
          ack_d = gnt;
          cnt_d = '0;
          if (ack_rd) begin
            state_d = DATA;
          end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            busy_d   = 1'b0;
          end
        end else if ((elig & gnt) == '0 || timed_out) begin
          to_d     = ((elig & gnt) != '0);
          state_d  = IDLE;
          cnt_d    = '0;
          gnt_d    = '0;
          gnt_id_d = '0;
          busy_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (rdata_vld_in || timed_out) begin
          rvld_d   = rdata_vld_in ? gnt : '0;
          to_d     = !rdata_vld_in;
          state_d  = IDLE;
          cnt_d    = '0;
          gnt_d    = '0;
          gnt_id_d = '0;
          busy_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(N_MAS - 1);
      cnt_q       <= '0;
      gnt         <= '0;
      gnt_id      <= '0;
      busy        <= 1'b0;
      ack         <= '0;
      rdata_vld   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt         <= gnt_d;
      gnt_id      <= gnt_id_d;
      busy        <= busy_d;
      ack         <= ack_d;
      rdata_vld   <= rvld_d;
      timeout_err <= to_d;
    end
  end
endmodule

// File: tb/tb_rr_ack_arbiter_n.sv
// Bench for rr_ack_arbiter_n: directed scenarios plus randomized traffic against an
// owner/pointer reference model.

module tb_rr_ack_arbiter_n;
  localparam int N = 4, SW = 2, TO = 8, IDW = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [SW-1:0] s_no = 2'd1;
  logic [N*SW-1:0] sfor = '0;
  logic [N*2-1:0] req_stat = '0;
  logic ack_in = 1'b0, ack_rd = 1'b0, rdata_vld_in = 1'b0;
  logic [N-1:0] ack, rdata_vld, gnt;
  logic [IDW-1:0] gnt_id;
  logic busy, timeout_err;

  int n_vec = 0, n_err = 0;

  int m_own, m_cnt, m_ptr;
  bit m_rd;
  logic [N-1:0] e_gnt, e_ack, e_rv;
  logic [IDW-1:0] e_id;
  logic e_busy, e_to;

  rr_ack_arbiter_n #(.N_MAS(N), .SW(SW), .TO_CYC(TO), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .s_no(s_no), .sfor(sfor), .req_stat(req_stat),
    .ack_in(ack_in), .ack_rd(ack_rd), .rdata_vld_in(rdata_vld_in),
    .ack(ack), .rdata_vld(rdata_vld), .gnt(gnt), .gnt_id(gnt_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_elig(int i);
    return (sfor[i*SW +: SW] == s_no) && (req_stat[2*i +: 2] == 2'd2);
  endfunction

  task automatic model_reset();
    m_own = -1; m_cnt = 0; m_ptr = N - 1; m_rd = 0;
    e_gnt = '0; e_ack = '0; e_rv = '0; e_id = '0; e_busy = 0; e_to = 0;
  endtask

  task automatic model_step();
    e_ack = '0; e_rv = '0; e_to = 0;
    if (m_own < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_elig(c)) begin
          m_own = c; m_ptr = c; m_cnt = 0; m_rd = 0;
          break;
        end
      end
    end else if (!m_rd) begin
      if (ack_in) begin
        e_ack = N'(1) << m_own;
        if (ack_rd) begin m_rd = 1; m_cnt = 0; end
        else m_own = -1;
      end else if (!m_elig(m_own)) m_own = -1;
      else if (m_cnt == TO - 1) begin e_to = 1; m_own = -1; end
      else m_cnt++;
    end else begin
      if (rdata_vld_in) begin e_rv = N'(1) << m_own; m_own = -1; end
      else if (m_cnt == TO - 1) begin e_to = 1; m_own = -1; end
      else m_cnt++;
    end
    if (m_own < 0) m_rd = 0;
    e_gnt  = (m_own >= 0) ? (N'(1) << m_own) : '0;
    e_id   = (m_own >= 0) ? IDW'(m_own) : '0;
    e_busy = (m_own >= 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic set_m(int i, int tgt, int st);
    sfor[i*SW +: SW] = SW'(tgt);
    req_stat[2*i +: 2] = 2'(st);
  endtask

  task automatic clear_all();
    sfor = '0; req_stat = '0; ack_in = 0; ack_rd = 0; rdata_vld_in = 0;
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({gnt, gnt_id, busy, ack, rdata_vld, timeout_err} !== '0) begin
      n_err++; $display("FAIL reset gnt=%b id=%0d busy=%b ack=%b rv=%b to=%b exp all 0",
                        gnt, gnt_id, busy, ack, rdata_vld, timeout_err);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_fairness();
    set_m(0, 1, 2); set_m(2, 1, 2);
    tick();
    n_vec++; if (gnt !== 4'b0001 || gnt_id !== 4'd0 || busy !== 1'b1) begin
      n_err++; $display("FAIL fair_g0 gnt=%b id=%0d busy=%b exp 0001/0/1", gnt, gnt_id, busy); end
    ack_in = 1; ack_rd = 0;
    tick();
    ack_in = 0;
    n_vec++; if (ack !== 4'b0001 || gnt !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL fair_ack0 ack=%b gnt=%b busy=%b exp 0001/0000/0", ack, gnt, busy); end
    tick();
    n_vec++; if (gnt !== 4'b0100 || gnt_id !== 4'd2 || ack !== 4'b0000) begin
      n_err++; $display("FAIL fair_g2 gnt=%b id=%0d ack=%b exp 0100/2/0000", gnt, gnt_id, ack); end
    ack_in = 1;
    tick();
    ack_in = 0;
    n_vec++; if (ack !== 4'b0100 || busy !== 1'b0) begin
      n_err++; $display("FAIL fair_ack2 ack=%b busy=%b exp 0100/0", ack, busy); end
    tick();
    n_vec++; if (gnt !== 4'b0001) begin
      n_err++; $display("FAIL fair_wrap gnt=%b exp 0001", gnt); end
    clear_all();
    tick();
  endtask

  task automatic test_read();
    set_m(3, 1, 2);
    tick();
    n_vec++; if (gnt !== 4'b1000 || gnt_id !== 4'd3) begin
      n_err++; $display("FAIL rd_gnt gnt=%b id=%0d exp 1000/3", gnt, gnt_id); end
    tick();
    rdata_vld_in = 1;
    tick();
    rdata_vld_in = 0;
    n_vec++; if (rdata_vld !== 4'b0000 || busy !== 1'b1) begin
      n_err++; $display("FAIL rd_stray_rv rv=%b busy=%b exp 0000/1", rdata_vld, busy); end
    ack_in = 1; ack_rd = 1;
    tick();
    ack_in = 0; ack_rd = 0;
    set_m(3, 1, 3);
    n_vec++; if (ack !== 4'b1000 || busy !== 1'b1 || gnt !== 4'b1000) begin
      n_err++; $display("FAIL rd_ack ack=%b busy=%b gnt=%b exp 1000/1/1000", ack, busy, gnt); end
    ack_in = 1;
    tick(); tick();
    ack_in = 0;
    n_vec++; if (ack !== 4'b0000 || busy !== 1'b1) begin
      n_err++; $display("FAIL rd_wait ack=%b busy=%b exp 0000/1", ack, busy); end
    tick();
    rdata_vld_in = 1;
    tick();
    rdata_vld_in = 0;
    n_vec++; if (rdata_vld !== 4'b1000 || busy !== 1'b0 || gnt !== 4'b0000) begin
      n_err++; $display("FAIL rd_data rv=%b busy=%b gnt=%b exp 1000/0/0000", rdata_vld, busy, gnt); end
    clear_all();
    tick();
  endtask

  task automatic test_withdraw();
    set_m(1, 1, 2); set_m(2, 1, 2);
    tick();
    n_vec++; if (gnt !== 4'b0010) begin
      n_err++; $display("FAIL wd_gnt gnt=%b exp 0010", gnt); end
    set_m(1, 1, 0);
    tick();
    n_vec++; if (gnt !== 4'b0000 || ack !== 4'b0000 || timeout_err !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL wd_drop gnt=%b ack=%b to=%b busy=%b exp 0000/0000/0/0",
                        gnt, ack, timeout_err, busy); end
    tick();
    n_vec++; if (gnt !== 4'b0100) begin
      n_err++; $display("FAIL wd_next gnt=%b exp 0100", gnt); end
    clear_all();
    tick();
  endtask

  task automatic test_timeout();
    set_m(0, 1, 2);
    tick();
    n_vec++; if (gnt !== 4'b0001) begin
      n_err++; $display("FAIL to_gnt gnt=%b exp 0001", gnt); end
    for (int c = 1; c < TO; c++) begin
      tick();
      n_vec++; if (timeout_err !== 1'b0 || gnt !== 4'b0001) begin
        n_err++; $display("FAIL to_early c=%0d to=%b gnt=%b exp 0/0001", c, timeout_err, gnt); end
    end
    tick();
    n_vec++; if (timeout_err !== 1'b1 || gnt !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL to_fire to=%b gnt=%b busy=%b exp 1/0000/0", timeout_err, gnt, busy); end
    tick();
    n_vec++; if (timeout_err !== 1'b0 || gnt !== 4'b0001) begin
      n_err++; $display("FAIL to_rearb to=%b gnt=%b exp 0/0001", timeout_err, gnt); end
    clear_all();
    tick();
  endtask

  task automatic test_stray();
    set_m(0, 2, 2);
    ack_in = 1; rdata_vld_in = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++; if (gnt !== 4'b0000 || ack !== 4'b0000 || rdata_vld !== 4'b0000 || busy !== 1'b0) begin
        n_err++; $display("FAIL stray gnt=%b ack=%b rv=%b busy=%b exp all 0", gnt, ack, rdata_vld, busy); end
    end
    clear_all();
    tick();
  endtask

  task automatic test_reset_mid();
    set_m(1, 1, 2);
    tick();
    ack_in = 1; ack_rd = 1;
    tick();
    ack_in = 0; ack_rd = 0;
    n_vec++; if (ack !== 4'b0010 || busy !== 1'b1) begin
      n_err++; $display("FAIL rst_pre ack=%b busy=%b exp 0010/1", ack, busy); end
    #2 rst_n = 1'b0;
    rdata_vld_in = 1;
    #1;
    model_reset();
    n_vec++; if ({gnt, gnt_id, busy, ack, rdata_vld, timeout_err} !== '0) begin
      n_err++; $display("FAIL rst_mid gnt=%b id=%0d busy=%b ack=%b rv=%b to=%b exp all 0",
                        gnt, gnt_id, busy, ack, rdata_vld, timeout_err); end
    tick();
    rdata_vld_in = 0;
    set_m(0, 1, 2);
    rst_n = 1'b1;
    tick();
    n_vec++; if (gnt !== 4'b0001 || gnt_id !== 4'd0 || rdata_vld !== 4'b0000) begin
      n_err++; $display("FAIL rst_first gnt=%b id=%0d rv=%b exp 0001/0/0000", gnt, gnt_id, rdata_vld); end
    clear_all();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0)
          set_m(i, int'($urandom_range(3)), ($urandom_range(1) == 1) ? 2 : int'($urandom_range(3)));
      ack_in = (c < 1500) ? ($urandom_range(3) == 0) : ($urandom_range(31) == 0);
      ack_rd = $urandom_range(1) == 1;
      rdata_vld_in = (c < 1500) ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
      if ($urandom_range(255) == 0) s_no = SW'($urandom_range(3));
      tick();
      n_vec++;
      if ({gnt, gnt_id, busy, ack, rdata_vld, timeout_err} !== {e_gnt, e_id, e_busy, e_ack, e_rv, e_to}) begin
        n_err++;
        $display("FAIL rand c=%0d gnt=%b id=%0d busy=%b ack=%b rv=%b to=%b exp gnt=%b id=%0d busy=%b ack=%b rv=%b to=%b",
                 c, gnt, gnt_id, busy, ack, rdata_vld, timeout_err, e_gnt, e_id, e_busy, e_ack, e_rv, e_to);
      end
    end
    clear_all();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fairness();
    test_read();
    test_withdraw();
    test_timeout();
    test_stray();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rr_ack_arbiter_n.md
Name: rr_ack_arbiter_n

Overview:
Per-slave round-robin arbiter, the N-master successor of the two-master ack arbiter.
- Selects one master whose request targets this slave and is in W_ACK state, then locks the grant for the whole transaction.
- Routes the slave's ack pulse to the owning master and, for reads, the following read-data-valid pulse.
- Releases on completion, request withdrawal or timeout.
- Sits between the slave port and the per-master request trackers.

Parameters:
N_MAS, 4, number of masters (2..16)
SW, 2, width of slave number / per-master target field
TO_CYC, 64, cycles allowed in GRANT or DATA before forced release; 0 disables the timeout
IDW, 4, width of gnt_id (must satisfy 2^IDW >= N_MAS)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_no  in  SW  this slave's number
sfor  in  N_MAS*SW  per-master target slave; master i in bits [i*SW +: SW]
req_stat  in  N_MAS*2  per-master status: 0 NO_REQ, 1 WAIT, 2 W_ACK, 3 W_DATA; master i in bits [2i +: 2]
ack_in  in  1  slave ack pulse
ack_rd  in  1  qualifies ack_in: 1 = read, data follows
rdata_vld_in  in  1  slave read-data-valid pulse
ack  out  N_MAS  routed ack, one-hot pulse
rdata_vld  out  N_MAS  routed read-data-valid, one-hot pulse
gnt  out  N_MAS  one-hot current owner
gnt_id  out  IDW  binary index of owner, 0 when idle
busy  out  1  high in GRANT or DATA
timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Reset values (async): all outputs 0, state IDLE, timeout counter 0, ptr = N_MAS-1, so master 0 wins first.
- elig[i] = (sfor[i] == s_no) && (req_stat[i] == 2).
- All outputs are registered.
- IDLE state:
  - If elig is non-zero, owner = first set bit searching ptr+1, ptr+2, ... modulo N_MAS.
  - Next cycle: gnt/gnt_id = owner, busy = 1, ptr <= owner, state GRANT, counter cleared.
  - Grant latency is 1 cycle after elig is asserted.
- GRANT state:
  - ack_in = 1: ack[owner] pulses on the next cycle (1-cycle latency).
    - ack_rd = 1: go to DATA, counter cleared.
    - ack_rd = 0: go to IDLE; gnt and busy drop in the same cycle as the ack pulse.
  - elig[owner] = 0 with no ack_in: withdrawal; go to IDLE silently, no ack.
  - ack_in in the same cycle as withdrawal: the ack wins.
- DATA state:
  - rdata_vld_in = 1: rdata_vld[owner] pulses on the next cycle; go to IDLE.
  - req_stat changes in DATA are ignored.
- Timeout: counter increments each cycle in GRANT or DATA.
  - When it reaches TO_CYC-1 with no completing event, timeout_err pulses, state goes to IDLE and ptr keeps owner.
  - A completing event in the same cycle wins.
- Out-of-state inputs: ack_in in IDLE/DATA and rdata_vld_in in IDLE/GRANT are dropped; ack and rdata_vld stay 0.
- Only the owner's ack/rdata_vld bit can be 1; every other bit is always 0.
- Back-to-back: after IDLE is re-entered, at least 1 IDLE cycle separates grants, and the next search starts at owner+1.
- A reset mid-transaction aborts it; no pulse is emitted.
- N_MAS = 1 degenerates to a lock/route FSM with no rotation.

Test Plan:
1. N_MAS=4, s_no=1; masters 0 and 2 target slave 1 in W_ACK; ack_in with ack_rd=0 each grant -> gnt 0001, ack[0] pulses, then gnt 0100, ack[2] pulses; next grant goes back to 0 (fairness).
2. Master 3 alone eligible; ack_in ack_rd=1 at cycle 3, rdata_vld_in at cycle 7 -> ack=1000 at cycle 4, rdata_vld=1000 at cycle 8, busy low at cycle 8.
3. Master 1 granted, then req_stat[1] goes to 0 before any ack -> returns to IDLE, no ack pulse, timeout_err=0; master 2 granted next if eligible.
4. TO_CYC=8; master 0 granted, no ack_in -> timeout_err pulses exactly 8 cycles after grant, gnt=0, then rearbitrate.
5. Master 0 targets slave 2 while s_no=1, plus a stray ack_in in IDLE -> no grant, ack=0000.
6. rst_n asserted low in DATA -> all outputs 0 immediately; after release, master 0 wins first.
